// File: rtl/wb_rr_arbiter_wdt.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter_wdt
//
// Two-master Wishbone pipelined arbiter with round-robin grant and a
// per-bus-cycle watchdog. Master A is the AXI-lite read path and master B is
// the AXI-lite write path. They share one downstream Wishbone slave port.
//
// A grant is held for as long as the owning master keeps its cyc high
// (cycle locking). The other master is stalled for that whole time.
//
// If the slave stays silent (no ack/err) for TIMEOUT consecutive granted
// cycles, the cycle is aborted:
//   - o_cyc is dropped.
//   - The owner receives a single err pulse.
//   - o_timeout pulses for one cycle.
//   - A saturating abort counter is bumped.
//
// Ports
//   i_clk, i_axi_reset_n         clock, synchronous active-low reset
//   i_a_* / o_a_*                master A: cyc, stb, we, adr, dat, sel in;
//                                stall, ack, err out
//   i_b_* / o_b_*                master B: same set as master A
//   o_cyc, o_stb, o_we, o_adr,   arbitrated Wishbone master port
//   o_dat, o_sel
//   i_stall, i_ack, i_err        slave responses
//   o_timeout                    one-cycle pulse in the first aborted cycle
//   o_timeout_cnt                saturating count of aborts since reset
// -----------------------------------------------------------------------------
module wb_rr_arbiter_wdt #(
    parameter int DW      = 32,
    parameter int AW      = 26,
    parameter int TIMEOUT = 10
) (
    input  logic            i_clk,
    input  logic            i_axi_reset_n,
    // master A (read path)
    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_adr,
    input  logic [DW-1:0]   i_a_dat,
    input  logic [DW/8-1:0] i_a_sel,
    output logic            o_a_stall,
    output logic            o_a_ack,
    output logic            o_a_err,
    // master B (write path)
    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_adr,
    input  logic [DW-1:0]   i_b_dat,
    input  logic [DW/8-1:0] i_b_sel,
    output logic            o_b_stall,
    output logic            o_b_ack,
    output logic            o_b_err,
    // arbitrated slave port
    output logic            o_cyc,
    output logic            o_stb,
    output logic            o_we,
    output logic [AW-1:0]   o_adr,
    output logic [DW-1:0]   o_dat,
    output logic [DW/8-1:0] o_sel,
    input  logic            i_stall,
    input  logic            i_ack,
    input  logic            i_err,
    // watchdog status
    output logic            o_timeout,
    output logic [7:0]      o_timeout_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    localparam logic       OWNER_A   = 1'b0;
    localparam logic       OWNER_B   = 1'b1;
    // Last silent cycle before the abort is declared.
    localparam logic [7:0] WDT_LIMIT = 8'(TIMEOUT - 1);
    localparam logic [7:0] CNT_MAX   = 8'hFF;

    state_t          state_q, state_d;
    // Owner of the cycle in progress. In ABORT it is still needed, so that
    // the err pulse is steered and the release of cyc is watched.
    logic            owner_q, owner_d;
    logic            last_owner_q, last_owner_d;
    logic [7:0]      wdt_q, wdt_d;
    // Set for exactly the first ABORT cycle. It drives both the owner's err
    // pulse and o_timeout.
    logic            abort_pulse_q, abort_pulse_d;
    logic [7:0]      timeout_cnt_q, timeout_cnt_d;

    logic            own_cyc_s;
    logic            own_stb_s;
    logic            own_we_s;
    logic [AW-1:0]   own_adr_s;
    logic [DW-1:0]   own_dat_s;
    logic [DW/8-1:0] own_sel_s;
    logic            slave_resp_s;

    // Select the request signals of whichever master currently owns the bus.
    always_comb begin
        if (owner_q == OWNER_B) begin
            own_cyc_s = i_b_cyc;
            own_stb_s = i_b_stb;
            own_we_s  = i_b_we;
            own_adr_s = i_b_adr;
            own_dat_s = i_b_dat;
            own_sel_s = i_b_sel;
        end else begin
            own_cyc_s = i_a_cyc;
            own_stb_s = i_a_stb;
            own_we_s  = i_a_we;
            own_adr_s = i_a_adr;
            own_dat_s = i_a_dat;
            own_sel_s = i_a_sel;
        end
    end

    assign slave_resp_s = i_ack | i_err;

    // Next-state logic: arbitration, cycle locking, watchdog and abort accounting.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        wdt_d         = wdt_q;
        abort_pulse_d = 1'b0;
        timeout_cnt_d = timeout_cnt_q;
        case (state_q)
            ST_IDLE: begin
                wdt_d = 8'd0;
                if (i_a_cyc && i_b_cyc) begin
                    // On a tie, the master that did not own the bus last wins.
                    if (last_owner_q == OWNER_A) begin
                        state_d = ST_GNT_B;
                        owner_d = OWNER_B;
                    end else begin
                        state_d = ST_GNT_A;
                        owner_d = OWNER_A;
                    end
                end else if (i_a_cyc) begin
                    state_d = ST_GNT_A;
                    owner_d = OWNER_A;
                end else if (i_b_cyc) begin
                    state_d = ST_GNT_B;
                    owner_d = OWNER_B;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT_A, ST_GNT_B: begin
                if (!own_cyc_s) begin
                    // Releasing cyc takes precedence over the watchdog limit.
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                    wdt_d        = 8'd0;
                end else if (slave_resp_s) begin
                    // A response on the limit cycle still counts, so no abort.
                    wdt_d = 8'd0;
                end else if (wdt_q == WDT_LIMIT) begin
                    state_d       = ST_ABORT;
                    wdt_d         = 8'd0;
                    abort_pulse_d = 1'b1;
                    if (timeout_cnt_q != CNT_MAX) begin
                        timeout_cnt_d = timeout_cnt_q + 8'd1;
                    end else begin
                        timeout_cnt_d = timeout_cnt_q;
                    end
                end else begin
                    wdt_d = wdt_q + 8'd1;
                end
            end
            ST_ABORT: begin
                wdt_d = 8'd0;
                // Hold off the bus until the aborted master has let go of cyc.
                if (!own_cyc_s) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                end else begin
                    state_d = ST_ABORT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wdt_d   = 8'd0;
            end
        endcase
    end

    // State registers. The reset wins over everything else, so an abort
    // pending at reset time is discarded without an err pulse.
    always_ff @(posedge i_clk) begin
        if (!i_axi_reset_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWNER_A;
            last_owner_q  <= OWNER_B;
            wdt_q         <= 8'd0;
            abort_pulse_q <= 1'b0;
            timeout_cnt_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            wdt_q         <= wdt_d;
            abort_pulse_q <= abort_pulse_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    // Output muxing from the registered state. Everything is forced quiet
    // (stalls high) while the reset input is low.
    always_comb begin
        o_cyc         = 1'b0;
        o_stb         = 1'b0;
        o_we          = 1'b0;
        o_adr         = {AW{1'b0}};
        o_dat         = {DW{1'b0}};
        o_sel         = {(DW/8){1'b0}};
        o_a_stall     = 1'b1;
        o_b_stall     = 1'b1;
        o_a_ack       = 1'b0;
        o_a_err       = 1'b0;
        o_b_ack       = 1'b0;
        o_b_err       = 1'b0;
        o_timeout     = 1'b0;
        o_timeout_cnt = 8'd0;
        if (!i_axi_reset_n) begin
            o_cyc = 1'b0;
        end else begin
            o_timeout     = abort_pulse_q;
            o_timeout_cnt = timeout_cnt_q;
            case (state_q)
                ST_GNT_A, ST_GNT_B: begin
                    o_cyc = own_cyc_s;
                    o_stb = own_cyc_s & own_stb_s;
                    o_we  = own_we_s;
                    o_adr = own_adr_s;
                    o_dat = own_dat_s;
                    o_sel = own_sel_s;
                    // Responses reach the owner even when its stb is low,
                    // which covers the tail of a pipelined burst.
                    if (owner_q == OWNER_B) begin
                        o_b_stall = i_stall;
                        o_b_ack   = i_ack;
                        o_b_err   = i_err;
                    end else begin
                        o_a_stall = i_stall;
                        o_a_ack   = i_ack;
                        o_a_err   = i_err;
                    end
                end
                ST_ABORT: begin
                    // Slave responses are ignored; only the timeout err is sent.
                    if (owner_q == OWNER_B) begin
                        o_b_err = abort_pulse_q;
                    end else begin
                        o_a_err = abort_pulse_q;
                    end
                end
                ST_IDLE: begin
                    o_cyc = 1'b0;
                end
                default: begin
                    o_cyc = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter_wdt.sv
module tb_wb_rr_arbiter_wdt;

    localparam int DW      = 32;
    localparam int AW      = 26;
    localparam int SW      = DW / 8;
    localparam int TIMEOUT = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
    logic [AW-1:0] a_adr, b_adr;
    logic [DW-1:0] a_dat, b_dat;
    logic [SW-1:0] a_sel, b_sel;
    logic          i_stall, i_ack, i_err;
    logic          o_a_stall, o_a_ack, o_a_err, o_b_stall, o_b_ack, o_b_err;
    logic          o_cyc, o_stb, o_we, o_timeout;
    logic [AW-1:0] o_adr;
    logic [DW-1:0] o_dat;
    logic [SW-1:0] o_sel;
    logic [7:0]    o_timeout_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bus (0 none, 1 A, 2 B), whether that
    // ownership has been aborted, consecutive silent cycles, and who owned
    // it last.
    int m_owner;
    bit m_abort;
    int m_quiet;
    int m_last;
    int m_aborts;
    bit m_pulse;

    logic          e_cyc, e_stb, e_we, e_a_stall, e_b_stall;
    logic          e_a_ack, e_a_err, e_b_ack, e_b_err, e_to;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    logic [7:0]    e_cnt;
    bit            quiet_ph;

    always #5 clk = ~clk;

    wb_rr_arbiter_wdt #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_axi_reset_n(rst_n),
        .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_adr(a_adr),
        .i_a_dat(a_dat), .i_a_sel(a_sel),
        .o_a_stall(o_a_stall), .o_a_ack(o_a_ack), .o_a_err(o_a_err),
        .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_adr(b_adr),
        .i_b_dat(b_dat), .i_b_sel(b_sel),
        .o_b_stall(o_b_stall), .o_b_ack(o_b_ack), .o_b_err(o_b_err),
        .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_adr(o_adr),
        .o_dat(o_dat), .o_sel(o_sel),
        .i_stall(i_stall), .i_ack(i_ack), .i_err(i_err),
        .o_timeout(o_timeout), .o_timeout_cnt(o_timeout_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_outputs();
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
        e_adr = '0; e_dat = '0; e_sel = '0;
        e_a_stall = 1'b1; e_b_stall = 1'b1;
        e_a_ack = 1'b0; e_a_err = 1'b0; e_b_ack = 1'b0; e_b_err = 1'b0;
        e_to = 1'b0; e_cnt = 8'd0;
        if (rst_n) begin
            e_to  = m_pulse;
            e_cnt = 8'(m_aborts);
            if (m_owner == 1 && !m_abort) begin
                e_cyc = a_cyc; e_stb = a_cyc & a_stb; e_we = a_we;
                e_adr = a_adr; e_dat = a_dat; e_sel = a_sel;
                e_a_stall = i_stall; e_a_ack = i_ack; e_a_err = i_err;
            end else if (m_owner == 2 && !m_abort) begin
                e_cyc = b_cyc; e_stb = b_cyc & b_stb; e_we = b_we;
                e_adr = b_adr; e_dat = b_dat; e_sel = b_sel;
                e_b_stall = i_stall; e_b_ack = i_ack; e_b_err = i_err;
            end else if (m_abort) begin
                e_a_err = m_pulse && (m_owner == 1);
                e_b_err = m_pulse && (m_owner == 2);
            end
        end
    endtask

    task automatic model_update();
        bit oc;
        if (!rst_n) begin
            m_owner = 0; m_abort = 0; m_quiet = 0; m_last = 2; m_aborts = 0; m_pulse = 0;
        end else begin
            m_pulse = 0;
            oc = (m_owner == 1) ? a_cyc : b_cyc;
            if (m_owner == 0) begin
                m_quiet = 0;
                if (a_cyc && b_cyc) m_owner = (m_last == 1) ? 2 : 1;
                else if (a_cyc)     m_owner = 1;
                else if (b_cyc)     m_owner = 2;
            end else if (m_abort) begin
                if (!oc) begin m_last = m_owner; m_owner = 0; m_abort = 0; end
            end else if (!oc) begin
                m_last = m_owner; m_owner = 0; m_quiet = 0;
            end else if (i_ack || i_err) begin
                m_quiet = 0;
            end else if (m_quiet + 1 == TIMEOUT) begin
                m_abort = 1; m_pulse = 1; m_quiet = 0;
                if (m_aborts < 255) m_aborts++;
            end else begin
                m_quiet++;
            end
        end
    endtask

    // Called at a negedge with the inputs already set: compares every output
    // against the model, advances one clock, and returns at the next negedge.
    task automatic tick();
        #2;
        model_outputs();
        check("cyc", o_cyc, e_cyc);
        check("stb", o_stb, e_stb);
        check("we", o_we, e_we);
        check("adr", o_adr, e_adr);
        check("dat", o_dat, e_dat);
        check("sel", o_sel, e_sel);
        check("a_stall", o_a_stall, e_a_stall);
        check("b_stall", o_b_stall, e_b_stall);
        check("a_ack", o_a_ack, e_a_ack);
        check("a_err", o_a_err, e_a_err);
        check("b_ack", o_b_ack, e_b_ack);
        check("b_err", o_b_err, e_b_err);
        check("timeout", o_timeout, e_to);
        check("timeout_cnt", o_timeout_cnt, e_cnt);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        a_cyc = 0; a_stb = 0; a_we = 0; a_adr = '0; a_dat = '0; a_sel = '0;
        b_cyc = 0; b_stb = 0; b_we = 0; b_adr = '0; b_dat = '0; b_sel = '0;
        i_stall = 0; i_ack = 0; i_err = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        idle_inputs();
        rst_n = 0;
        m_owner = 0; m_abort = 0; m_quiet = 0; m_last = 2; m_aborts = 0; m_pulse = 0;
        quiet_ph = 0;
        @(negedge clk);

        // 1: reset, then a single grant to A
        do_reset();
        check("reset_cyc", o_cyc, 1'b0);
        check("reset_a_stall", o_a_stall, 1'b1);
        check("reset_cnt", o_timeout_cnt, 8'd0);
        a_cyc = 1; a_stb = 1; a_adr = 26'h10; a_dat = 32'hCAFE0001; a_sel = 4'hF;
        tick();
        check("t1_cyc", o_cyc, 1'b1);
        check("t1_adr", o_adr, 26'h10);
        i_ack = 1;
        #1;
        check("t1_a_ack", o_a_ack, 1'b1);
        check("t1_b_ack", o_b_ack, 1'b0);
        tick();
        i_ack = 0; a_stb = 0; a_cyc = 0;
        tick();

        // 2: alternation when both request together
        do_reset();
        a_cyc = 1; a_stb = 1; b_cyc = 1; b_stb = 1;
        tick();
        check("t2_first_a", o_a_stall, 1'b0);
        check("t2_first_b", o_b_stall, 1'b1);
        a_cyc = 0;
        tick();
        a_cyc = 1;
        tick();
        check("t2_second_b", o_b_stall, 1'b0);
        check("t2_second_a", o_a_stall, 1'b1);
        b_cyc = 0;
        tick();
        b_cyc = 1;
        tick();
        check("t2_third_a", o_a_stall, 1'b0);
        a_cyc = 0; b_cyc = 0;
        tick();

        // 3: B owns a pipelined burst while A waits
        do_reset();
        b_cyc = 1; b_stb = 1; b_we = 1;
        tick();
        a_cyc = 1; a_stb = 1;
        for (int i = 0; i < 4; i++) begin
            b_adr = 26'(i); b_dat = 32'(32'h100 + i);
            b_stb = (i < 3); i_ack = (i >= 1);
            #1;
            check("t3_a_stall", o_a_stall, 1'b1);
            tick();
        end
        i_ack = 0; b_cyc = 0; b_stb = 0;
        tick();
        check("t3_gap_cyc", o_cyc, 1'b0);
        tick();
        check("t3_a_cyc", o_cyc, 1'b1);
        check("t3_a_stall_low", o_a_stall, 1'b0);

        // 4: A owns, slave never answers
        a_cyc = 0; a_stb = 0;
        tick();
        a_cyc = 1; a_stb = 1; a_adr = 26'h20;
        tick();
        for (int i = 0; i < TIMEOUT; i++) tick();
        check("t4_cyc", o_cyc, 1'b0);
        check("t4_a_err", o_a_err, 1'b1);
        check("t4_timeout", o_timeout, 1'b1);
        check("t4_cnt", o_timeout_cnt, 8'd1);
        tick();
        check("t4_err_once", o_a_err, 1'b0);
        check("t4_to_once", o_timeout, 1'b0);

        // 5: ack on the last cycle before the limit
        a_cyc = 0;
        tick();
        a_cyc = 1;
        tick();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        i_ack = 1;
        #1;
        check("t5_a_ack", o_a_ack, 1'b1);
        tick();
        i_ack = 0;
        check("t5_cyc", o_cyc, 1'b1);
        check("t5_timeout", o_timeout, 1'b0);
        check("t5_cnt", o_timeout_cnt, 8'd1);

        // 6: reset while B owns the bus
        a_cyc = 0; a_stb = 0;
        tick();
        b_cyc = 1; b_stb = 1;
        tick();
        tick();
        rst_n = 0;
        #1;
        check("t6_cyc_now", o_cyc, 1'b0);
        check("t6_b_stall_now", o_b_stall, 1'b1);
        tick();
        check("t6_b_err", o_b_err, 1'b0);
        check("t6_cnt", o_timeout_cnt, 8'd0);
        check("t6_a_stall", o_a_stall, 1'b1);
        rst_n = 1; b_cyc = 0; b_stb = 0;
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 11) == 0) a_cyc = ~a_cyc;
            if ($urandom_range(0, 11) == 0) b_cyc = ~b_cyc;
            if ($urandom_range(0, 39) == 0) quiet_ph = ~quiet_ph;
            a_stb = 1'($urandom_range(0, 1)); b_stb = 1'($urandom_range(0, 1));
            a_we = 1'($urandom_range(0, 1));  b_we = 1'($urandom_range(0, 1));
            a_adr = 26'($urandom); b_adr = 26'($urandom);
            a_dat = $urandom; b_dat = $urandom;
            a_sel = 4'($urandom); b_sel = 4'($urandom);
            i_stall = ($urandom_range(0, 3) == 0);
            i_ack = !quiet_ph && ($urandom_range(0, 3) == 0);
            i_err = !quiet_ph && ($urandom_range(0, 24) == 0);
            rst_n = ($urandom_range(0, 399) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
